// File: rtl/ft245_resp_pkg.sv
// Shared definitions for the FT245-style device-side responder.
//   state_t          : host-strobe FSM states
//   BYTE_W           : width of every data byte on the bus and the streams
//   DEFAULT_DEPTH    : default entries per RX/TX buffer
//   DEFAULT_RECOVERY : default cycles the flags stay high after a strobe ends
package ft245_resp_pkg;

    localparam int BYTE_W           = 8;
    localparam int DEFAULT_DEPTH    = 16;
    localparam int DEFAULT_RECOVERY = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_ACTIVE,
        WR_ACTIVE,
        RECOVER
    } state_t;

endpackage

// File: rtl/ft245_resp_fifo.sv
// Synchronous byte FIFO used for both the RX and TX buffers of the responder.
// The head entry is presented combinationally so a pop and its data share a cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and byte (ignored while full)
//   pop             : read request (ignored while empty)
//   head            : byte at the read pointer
//   full, empty     : status
//   count           : number of stored entries, 0..DEPTH
module ft245_resp_fifo
    import ft245_resp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ft245_fifo_responder.sv
// Device-side responder for an FT245-style asynchronous byte FIFO bus.
// Serves host reads from an RX buffer filled by a valid/ready stream and
// captures host writes into a TX buffer drained to a valid/ready stream.
// Optional feature macro: FT245_RESP_SIWU_EN (batch-gated TX stream, see below).
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   iRD_n, iWR_n, iSIWU_n, iDATA    : host strobes / send-immediate / write data
//   oDATA, oDATA_OE                 : read data and its tristate enable
//   oRXF_n, oTXE_n                  : low = readable / writable
//   iRX_DATA, iRX_VALID, oRX_READY  : stream into the RX buffer
//   oTX_DATA, oTX_VALID, iTX_READY  : stream out of the TX buffer
//   oERR                            : sticky protocol-violation flag
module ft245_fifo_responder
    import ft245_resp_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int RECOVERY   = DEFAULT_RECOVERY,
    parameter int PKT_THRESH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iRD_n,
    input  logic              iWR_n,
    input  logic              iSIWU_n,
    input  logic [BYTE_W-1:0] iDATA,
    output logic [BYTE_W-1:0] oDATA,
    output logic              oDATA_OE,
    output logic              oRXF_n,
    output logic              oTXE_n,
    input  logic [BYTE_W-1:0] iRX_DATA,
    input  logic              iRX_VALID,
    output logic              oRX_READY,
    output logic [BYTE_W-1:0] oTX_DATA,
    output logic              oTX_VALID,
    input  logic              iTX_READY,
    output logic              oERR
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

    logic              rd_r, wr_r;
    logic [BYTE_W-1:0] data_r;
    state_t            state, state_next;
    logic              rx_pop, tx_push, err_set;
    logic              rxf_d, txe_d;
    logic              hold;
    logic              ready_en;
    logic [RW-1:0]     rec_cnt;
    logic [BYTE_W-1:0] rx_head;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0]     rx_count_unused;
    logic [CW-1:0]     tx_count;

    // Host pins are registered once; the FSM only ever sees these copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_r   <= 1'b1;
            wr_r   <= 1'b1;
            data_r <= '0;
        end else begin
            rd_r   <= iRD_n;
            wr_r   <= iWR_n;
            data_r <= iDATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // hold blocks a rejected strobe from being retried until the host lets go.
    always_comb begin
        state_next = state;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!hold) begin
                    if (!rd_r) begin
                        if (!wr_r) err_set = 1'b1;
                        if (!rx_empty) begin
                            rx_pop     = 1'b1;
                            state_next = RD_ACTIVE;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else if (!wr_r) begin
                        if (!tx_full) begin
                            tx_push    = 1'b1;
                            state_next = WR_ACTIVE;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
            end
            RD_ACTIVE: if (rd_r) state_next = RECOVER;
            WR_ACTIVE: if (wr_r) state_next = RECOVER;
            RECOVER:   if (rec_cnt == RW'(RECOVERY - 1)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Flags report buffer status only while idle with nothing starting.
    always_comb begin
        rxf_d = 1'b1;
        txe_d = 1'b1;
        if (state == IDLE && !rx_pop && !tx_push) begin
            rxf_d = rx_empty;
            txe_d = tx_full;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oRXF_n   <= 1'b1;
            oTXE_n   <= 1'b1;
            oDATA    <= '0;
            oDATA_OE <= 1'b0;
            oERR     <= 1'b0;
            hold     <= 1'b0;
            rec_cnt  <= '0;
            ready_en <= 1'b0;
        end else begin
            oRXF_n   <= rxf_d;
            oTXE_n   <= txe_d;
            oDATA_OE <= (state_next == RD_ACTIVE);
            ready_en <= 1'b1;
            if (rx_pop)  oDATA <= rx_head;
            if (err_set) oERR  <= 1'b1;
            if (rd_r && wr_r)  hold <= 1'b0;
            else if (err_set)  hold <= 1'b1;
            rec_cnt <= (state == RECOVER) ? rec_cnt + 1'b1 : '0;
        end
    end

    assign oRX_READY = ready_en & ~rx_full;

    ft245_resp_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (iRX_VALID & oRX_READY),
        .push_data (iRX_DATA),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count_unused)
    );

    ft245_resp_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (data_r),
        .pop       (oTX_VALID & iTX_READY),
        .head      (oTX_DATA),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

`ifdef FT245_RESP_SIWU_EN
    logic siwu_r, siwu_prev, batch_open;

    // A batch stays open until the TX buffer has fully drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            siwu_r     <= 1'b1;
            siwu_prev  <= 1'b1;
            batch_open <= 1'b0;
        end else begin
            siwu_r    <= iSIWU_n;
            siwu_prev <= siwu_r;
            if (tx_empty)
                batch_open <= 1'b0;
            else if (tx_count >= CW'(PKT_THRESH) || (siwu_prev && !siwu_r))
                batch_open <= 1'b1;
        end
    end

    assign oTX_VALID = batch_open & ~tx_empty;
`else
    localparam int pkt_thresh_unused = PKT_THRESH;
    logic siwu_unused;
    assign siwu_unused = ^{iSIWU_n, tx_count};
    assign oTX_VALID   = ~tx_empty;
`endif

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Directed bench for ft245_fifo_responder: reset values, stream-fed reads,
// write-to-full with overflow error, read/write collision, reset during a read,
// and (when FT245_RESP_SIWU_EN is defined) batch-gated TX draining.
module tb_ft245_fifo_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       iRD_n, iWR_n, iSIWU_n;
    logic [7:0] iDATA;
    logic [7:0] oDATA;
    logic       oDATA_OE, oRXF_n, oTXE_n;
    logic [7:0] iRX_DATA;
    logic       iRX_VALID, oRX_READY;
    logic [7:0] oTX_DATA;
    logic       oTX_VALID, iTX_READY;
    logic       oERR;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ft245_fifo_responder dut (
        .clk       (clk),
        .rst       (rst),
        .iRD_n     (iRD_n),
        .iWR_n     (iWR_n),
        .iSIWU_n   (iSIWU_n),
        .iDATA     (iDATA),
        .oDATA     (oDATA),
        .oDATA_OE  (oDATA_OE),
        .oRXF_n    (oRXF_n),
        .oTXE_n    (oTXE_n),
        .iRX_DATA  (iRX_DATA),
        .iRX_VALID (iRX_VALID),
        .oRX_READY (oRX_READY),
        .oTX_DATA  (oTX_DATA),
        .oTX_VALID (oTX_VALID),
        .iTX_READY (iTX_READY),
        .oERR      (oERR)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_push(input logic [7:0] b);
        iRX_DATA  = b;
        iRX_VALID = 1'b1;
        @(negedge clk);
        iRX_VALID = 1'b0;
    endtask

    // Two-cycle RD_n pulse; optionally WR_n low at the same time.
    task automatic rd_pulse(input string tag, input logic [7:0] exp, input logic wr_too);
        iRD_n = 1'b0;
        if (wr_too) begin
            iWR_n = 1'b0;
            iDATA = 8'h99;
        end
        cyc(2);
        check({tag, "_oe"},   {7'd0, oDATA_OE}, 8'd1);
        check({tag, "_data"}, oDATA, exp);
        check({tag, "_rxf"},  {7'd0, oRXF_n}, 8'd1);
        iRD_n = 1'b1;
        iWR_n = 1'b1;
        cyc(1);
        check({tag, "_oe_hold"}, {7'd0, oDATA_OE}, 8'd1);
        cyc(1);
        check({tag, "_oe_off"}, {7'd0, oDATA_OE}, 8'd0);
        cyc(3);
    endtask

    task automatic wr_pulse(input logic [7:0] b);
        iWR_n = 1'b0;
        iDATA = b;
        cyc(2);
        iWR_n = 1'b1;
        cyc(5);
    endtask

    task automatic tx_collect(input string tag, input int n, input logic [7:0] base);
        int got = 0;
        for (int k = 0; k < 80 && got < n; k++) begin
            @(negedge clk);
            if (oTX_VALID) begin
                check({tag, "_byte"}, oTX_DATA, 8'(base + got));
                got++;
            end
        end
        check({tag, "_count"}, 8'(got), 8'(n));
        cyc(1);
        check({tag, "_valid_off"}, {7'd0, oTX_VALID}, 8'd0);
    endtask

    initial begin
        rst       = 1'b0;
        iRD_n     = 1'b1;
        iWR_n     = 1'b1;
        iSIWU_n   = 1'b1;
        iDATA     = 8'h00;
        iRX_DATA  = 8'h00;
        iRX_VALID = 1'b0;
        iTX_READY = 1'b0;

        // Reset values
        cyc(2);
        check("rst_rxf",   {7'd0, oRXF_n},    8'd1);
        check("rst_txe",   {7'd0, oTXE_n},    8'd1);
        check("rst_data",  oDATA,             8'h00);
        check("rst_oe",    {7'd0, oDATA_OE},  8'd0);
        check("rst_ready", {7'd0, oRX_READY}, 8'd0);
        check("rst_valid", {7'd0, oTX_VALID}, 8'd0);
        check("rst_err",   {7'd0, oERR},      8'd0);
        rst = 1'b1;
        cyc(1);
        check("rel_txe",   {7'd0, oTXE_n},    8'd0);
        check("rel_rxf",   {7'd0, oRXF_n},    8'd1);
        check("rel_ready", {7'd0, oRX_READY}, 8'd1);

        // Reads in stream order
        rx_push(8'hA5);
        rx_push(8'h5A);
        rx_push(8'h3C);
        cyc(1);
        check("rd_rxf_low", {7'd0, oRXF_n}, 8'd0);
        rd_pulse("rd0", 8'hA5, 1'b0);
        check("rd0_rxf_after", {7'd0, oRXF_n}, 8'd0);
        rd_pulse("rd1", 8'h5A, 1'b0);
        rd_pulse("rd2", 8'h3C, 1'b0);
        check("rd_rxf_empty", {7'd0, oRXF_n}, 8'd1);
        check("rd_err",       {7'd0, oERR},   8'd0);

        // Write to full, then overflow
        for (int i = 0; i < 15; i++) wr_pulse(8'h80 + 8'(i));
        check("wr15_txe", {7'd0, oTXE_n}, 8'd0);
        wr_pulse(8'h8F);
        check("wr16_txe",   {7'd0, oTXE_n},    8'd1);
        check("wr16_valid", {7'd0, oTX_VALID}, 8'd1);
        check("wr16_err",   {7'd0, oERR},      8'd0);
        wr_pulse(8'hEE);
        check("wr17_err", {7'd0, oERR},   8'd1);
        check("wr17_txe", {7'd0, oTXE_n}, 8'd1);
        iTX_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", {7'd0, oTX_VALID}, 8'd1);
            check("drain_data",  oTX_DATA, 8'h80 + 8'(i));
            cyc(1);
        end
        check("drain_empty", {7'd0, oTX_VALID}, 8'd0);
        iTX_READY = 1'b0;
        cyc(1);
        check("drain_txe", {7'd0, oTXE_n}, 8'd0);

        // Reset while the RX stream is active
        rx_push(8'h77);
        iRX_DATA  = 8'h78;
        iRX_VALID = 1'b1;
        rst = 1'b0;
        #1;
        check("mrst_rxf",   {7'd0, oRXF_n},    8'd1);
        check("mrst_txe",   {7'd0, oTXE_n},    8'd1);
        check("mrst_data",  oDATA,             8'h00);
        check("mrst_ready", {7'd0, oRX_READY}, 8'd0);
        check("mrst_err",   {7'd0, oERR},      8'd0);
        iRX_VALID = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check("mrst_rel_rxf", {7'd0, oRXF_n}, 8'd1);
        check("mrst_rel_txe", {7'd0, oTXE_n}, 8'd0);

        // Collision: read wins, write dropped, error flagged
        rx_push(8'h11);
        cyc(1);
        check("col_rxf_low", {7'd0, oRXF_n}, 8'd0);
        rd_pulse("col", 8'h11, 1'b1);
        check("col_err",   {7'd0, oERR},      8'd1);
        check("col_txcnt", {7'd0, oTX_VALID}, 8'd0);
        check("col_txe",   {7'd0, oTXE_n},    8'd0);

        // Reset in the middle of a read
        rx_push(8'h22);
        cyc(1);
        iRD_n = 1'b0;
        cyc(2);
        check("rdrst_oe_on", {7'd0, oDATA_OE}, 8'd1);
        rst = 1'b0;
        #1;
        check("rdrst_oe_off", {7'd0, oDATA_OE}, 8'd0);
        check("rdrst_data",   oDATA,            8'h00);
        iRD_n = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(2);
        check("rdrst_rxf", {7'd0, oRXF_n}, 8'd1);
        rx_push(8'h33);
        cyc(1);
        rd_pulse("rdrst_next", 8'h33, 1'b0);
        check("rdrst_rxf_end", {7'd0, oRXF_n}, 8'd1);

`ifdef FT245_RESP_SIWU_EN
        // Batch gating of the TX stream
        iTX_READY = 1'b1;
        for (int i = 0; i < 3; i++) wr_pulse(8'hC0 + 8'(i));
        check("siwu_held", {7'd0, oTX_VALID}, 8'd0);
        iSIWU_n = 1'b0;
        cyc(1);
        iSIWU_n = 1'b1;
        tx_collect("siwu3", 3, 8'hC0);
        for (int i = 0; i < 7; i++) wr_pulse(8'hD0 + 8'(i));
        check("thr_held", {7'd0, oTX_VALID}, 8'd0);
        fork
            wr_pulse(8'hD7);
            tx_collect("thr8", 8, 8'hD0);
        join
        iTX_READY = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft245_fifo_responder.md
# ft245_fifo_responder

Device-side responder for the FT245-style asynchronous byte FIFO bus, i.e. the far end of the host interface that drives RD_n/WR_n and samples RXF_n/TXE_n. It presents RXF_n/TXE_n, serves host reads from an internal RX buffer filled by a valid/ready byte stream, and captures host writes into a TX buffer drained to a valid/ready byte stream. It is used as a synthesizable loopback and emulation partner for the host FIFO logic on the DE0-Nano, for example in an FPGA-to-FPGA link or a self-test build.

## Interface
- DEPTH, 16: entries per buffer; power of two, ≥4.
- RECOVERY, 2: cycles RXF_n/TXE_n are forced high after each strobe ends; ≥1.
- PKT_THRESH, 8: TX batch threshold, used only with SIWU; 1..DEPTH.

Ports:
- clk  in  1  system clock; all inputs share it.
- rst  in  1  asynchronous, active-low reset.
- iRD_n  in  1  host read strobe.
- iWR_n  in  1  host write strobe.
- iSIWU_n  in  1  send-immediate; see Configuration.
- iDATA  in  8  host write data.
- oDATA  out  8  read data toward host.
- oDATA_OE  out  1  tristate enable for oDATA at the top-level buffer.
- oRXF_n  out  1  low = a byte is readable.
- oTXE_n  out  1  low = a byte is writable.
- iRX_DATA  in  8  / iRX_VALID in 1 / oRX_READY out 1: stream into the RX buffer.
- oTX_DATA  out  8  / oTX_VALID out 1 / iTX_READY in 1: stream out of the TX buffer.
- oERR  out  1  sticky protocol-violation flag.

## Operation
- iRD_n, iWR_n, iSIWU_n and iDATA are registered once on entry. The FSM acts only on the registered copies.
- FSM states: IDLE, RD_ACTIVE, WR_ACTIVE, RECOVER.
- IDLE, registered RD_n low and RX non-empty:
  - pop the RX head into oDATA;
  - set oDATA_OE=1 and oRXF_n=1;
  - go to RD_ACTIVE.
- IDLE, registered WR_n low and TX not full:
  - push the registered iDATA;
  - set oTXE_n=1;
  - go to WR_ACTIVE.
- RD_ACTIVE: hold oDATA. When registered RD_n goes high, clear oDATA_OE and go to RECOVER.
- WR_ACTIVE: when registered WR_n goes high, go to RECOVER.
- RECOVER: count RECOVERY cycles with oRXF_n=oTXE_n=1, then return to IDLE.
- In IDLE, oRXF_n = RX empty and oTXE_n = TX full, both registered.
- Both strobes low in IDLE: the read wins, the write is ignored, oERR is set.
- Strobe asserted while the matching flag is high (read from empty, write to full):
  - the transfer is ignored with no pop, no push and OE unchanged;
  - oERR is set;
  - the FSM stays in IDLE until the strobe is released.
- Stream side runs independently of the FSM:
  - oRX_READY = RX not full; a push happens on valid&ready;
  - oTX_VALID = TX non-empty (gated per Configuration); a pop happens on valid&ready.
- FIFO pointers are DEPTH-wrapping with one extra bit for full/empty. A simultaneous push and pop on the same buffer keeps the count unchanged.
- Reset, including mid-operation: FSM to IDLE, both buffers emptied, any in-flight host byte discarded.
- Reset values: oRXF_n=1, oTXE_n=1, oDATA=0, oDATA_OE=0, oRX_READY=0, oTX_VALID=0, oERR=0.

## Timing
- Host strobe latency: strobe falls at the pin before edge n → registered at n → FSM acts at n+1.
- Read: oDATA and oDATA_OE are valid after edge n+1 and held until 2 edges after RD_n rises.
- Flag latency: oRXF_n/oTXE_n change 1 cycle after a stream-side push/pop in IDLE.
- Cycle cost: minimum transfer is 1 strobe-low cycle + 1 detect + RECOVERY = 4 cycles per byte at defaults.
- oRX_READY deasserts in the same cycle the RX count reaches DEPTH.

## Configuration
- FT245_RESP_SIWU_EN defined: oTX_VALID asserts only while a batch is open.
  - A batch opens when the TX count ≥ PKT_THRESH, or on a registered iSIWU_n falling edge with TX non-empty.
  - It closes when TX is empty.
- FT245_RESP_SIWU_EN undefined: oTX_VALID = TX non-empty, iSIWU_n is ignored, PKT_THRESH is unused.

## Structure
- Package ft245_resp_pkg holds:
  - the FSM state enum (IDLE, RD_ACTIVE, WR_ACTIVE, RECOVER);
  - DEFAULT_DEPTH and DEFAULT_RECOVERY;
  - the byte-width constant 8.
- Sub-module ft245_resp_fifo: synchronous FIFO with full/empty/count outputs, instantiated twice (RX and TX).

## Test plan
- Reset: assert rst=0 mid-stream → all outputs at reset values. Release → oTXE_n=0 after 1 cycle, oRXF_n=1.
- Read: stream in 0xA5, 0x5A, 0x3C, then do three RD_n pulses (2 cycles low) → oDATA reads A5, 5A, 3C in order, with oDATA_OE high only during each pulse+1. oRXF_n=1 after the third read.
- Write to full: 16 WR_n pulses with iTX_READY=0 → oTXE_n stays high after the 16th. A 17th pulse sets oERR and leaves the count at 16. Setting iTX_READY=1 then drains 16 bytes in order.
- Collision: RD_n and WR_n low in the same cycle with RX holding 0x11 → read of 0x11 completes, TX count unchanged, oERR=1.
- SIWU (macro defined): write 3 bytes → oTX_VALID=0. Pulse iSIWU_n → 3 bytes drain, then oTX_VALID=0. Write 8 bytes → drain starts without SIWU.
- Reset mid-read (RD_ACTIVE) → oDATA_OE=0 at once. After release, oRXF_n=1 and the first stream byte pushed afterwards is the next byte read.
